load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max cycles mem_req is held without mem_ack before a fault.
REQ-002 clock  input  1  clock; all state updates on posedge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 ls_valid  input  1  M stage holds a load/store; held stable while ls_stall=1.
REQ-005 ls_write  input  1  1=store, 0=load.
REQ-006 ls_funct3  input  3  RISC-V load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 ls_addr  input  32  byte address (M-stage ALU result).
REQ-008 ls_wdata  input  32  store data (rs2), low-aligned.
REQ-009 ls_stall  output  1  freezes the pipeline while an access is in flight.
REQ-010 ls_done  output  1  one-cycle pulse: access complete.
REQ-011 ls_rdata  output  32  aligned, extended load data; valid when ls_done=1.
REQ-012 ls_fault  output  1  qualifies ls_done: misaligned, illegal funct3 or timeout.
REQ-013 mem_req  output  1  memory request, held until mem_ack.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  32  word address {ls_addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-019 mem_rdata  input  32  read word, valid with mem_ack.

Function
REQ-020 FSM states IDLE, REQ, RESP; IDLE on reset.
REQ-021 IDLE: ls_valid=1 accepts op (capture write, funct3, addr, wdata); legal+aligned -> REQ, else -> RESP with fault.
REQ-022 ls_stall = (IDLE & ls_valid) | REQ; 0 in RESP.
REQ-023 REQ: mem_req=1, mem_we/addr/wdata/be constant from captured op; mem_ack=1 -> capture mem_rdata, -> RESP.
REQ-024 RESP: ls_done=1 for exactly one cycle, ls_fault as determined, -> IDLE unconditionally; ls_valid in RESP is not re-accepted.
REQ-025 Latency: accept in cycle N, mem_req from N+1, ack in cycle K>=N+1, ls_done in K+1; zero-wait ack gives done at N+2.
REQ-026 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 011,110,111 (loads) or >=011 (stores) illegal; no mem_req issued; done+fault at N+1.
REQ-027 Timeout: counter cleared on REQ entry, increments per REQ cycle without ack; after mem_req held TIMEOUT_CYCLES cycles -> drop mem_req, RESP with fault, ls_rdata=0.
REQ-028 Simultaneous ack and timeout in same cycle: ack wins, no fault.
REQ-029 Stores: SB be=1<<addr[1:0], wdata byte replicated x4; SH be=0011 (addr[1]=0) / 1100 (addr[1]=1), halfword replicated x2; SW be=1111.
REQ-030 Loads: mem_be per REQ-029 sizing; LB/LH sign-extend selected lane, LBU/LHU zero-extend, LW passthrough.
REQ-031 Store completion: ls_rdata=0 on done.
REQ-032 mem_ack outside REQ is ignored.

Reset
REQ-033 reset -> IDLE, counter 0; ls_stall, ls_done, ls_fault, mem_req, mem_we=0; mem_addr, mem_wdata, ls_rdata=0; mem_be=0000.
REQ-034 Reset mid-access abandons the op; mem_req=0 the cycle after reset is sampled; a late ack is discarded.

Structure
REQ-035 Shared package lsu_pkg holds FSM state enum, funct3 constants (LB..SW), byte-enable constants.
REQ-036 Combinational sub-module lsu_align does lane select, extension, byte-enable and store replication; FSM, counter and capture registers live in load_store_unit.

Verification
REQ-037 LW 0x01000104, ack 2 cycles after mem_req, rdata 0xDEADBEEF -> mem_addr 0x01000104, be 1111, ls_done one cycle later, ls_rdata 0xDEADBEEF, ls_stall high 3 cycles.
REQ-038 LB 0x01000103, mem_rdata 0x80AA55CC -> ls_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x01000102 -> 0x000080AA.
REQ-039 SH 0x01000102, wdata 0x1234ABCD -> mem_we 1, be 1100, mem_wdata 0xABCDABCD, mem_addr 0x01000100, ls_rdata 0.
REQ-040 LW 0x01000102 -> no mem_req, ls_done+ls_fault next cycle, ls_stall high 1 cycle.
REQ-041 TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then done+fault, rdata 0; ack in 4th cycle -> normal completion.
REQ-042 reset asserted in REQ, ack one cycle later -> mem_req 0, no ls_done, next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// ------------------------------------------------------------------
// lsu_pkg : shared types and constants for the load/store unit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // True when funct3 is a legal access size for the direction and the address is naturally aligned.
   function automatic logic lsu_op_legal(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      if (is_store) begin
         case (funct3)
            F3_SB:   ok = 1'b1;
            F3_SH:   ok = ~addr_lo[0];
            F3_SW:   ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~addr_lo[0];
            F3_LW:         ok = (addr_lo == 2'b00);
            default:       ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ------------------------------------------------------------------
// lsu_align : byte enables, store lane replication, load lane select/extend
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] read_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_lanes,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      byte_en     = BE_NONE;
      store_lanes = '0;
      load_data   = '0;
      sel_byte    = read_word[{addr_lo, 3'b000} +: 8];
      sel_half    = addr_lo[1] ? read_word[31:16] : read_word[15:0];

      // funct3[1:0] is the access size; funct3[2] selects zero-extension for loads.
      case (funct3[1:0])
         2'b00: begin
            byte_en     = BE_BYTE0 << addr_lo;
            store_lanes = {4{store_data[7:0]}};
            load_data   = funct3[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
         end
         2'b01: begin
            byte_en     = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            store_lanes = {2{store_data[15:0]}};
            load_data   = funct3[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
         end
         2'b10: begin
            byte_en     = BE_WORD;
            store_lanes = store_data;
            load_data   = read_word;
         end
         default: begin
            byte_en     = BE_NONE;
            store_lanes = '0;
            load_data   = '0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ------------------------------------------------------------------
// load_store_unit : M-stage load/store sequencer with bus timeout
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ls_valid,
   input  logic        ls_write,
   input  logic [2:0]  ls_funct3,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_stall,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        ls_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e       state_q,  state_d;
   logic             write_q,  write_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [31:0]      addr_q,   addr_d;
   logic [31:0]      wdata_q,  wdata_d;
   logic             fault_q,  fault_d;
   logic [31:0]      rdata_q,  rdata_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic [3:0]  align_be;
   logic [31:0] align_wdata;
   logic [31:0] align_ldata;

   lsu_align u_align (
      .funct3      (funct3_q),
      .addr_lo     (addr_q[1:0]),
      .store_data  (wdata_q),
      .read_word   (mem_rdata),
      .byte_en     (align_be),
      .store_lanes (align_wdata),
      .load_data   (align_ldata)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         fault_q  <= 1'b0;
         rdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         fault_q  <= fault_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      funct3_d  = funct3_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      fault_d   = fault_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      ls_stall  = 1'b0;
      ls_done   = 1'b0;
      ls_fault  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = BE_NONE;

      case (state_q)
         ST_IDLE: begin
            if (ls_valid) begin
               ls_stall = 1'b1;
               write_d  = ls_write;
               funct3_d = ls_funct3;
               addr_d   = ls_addr;
               wdata_d  = ls_wdata;
               rdata_d  = '0;
               cnt_d    = '0;
               if (lsu_op_legal(ls_write, ls_funct3, ls_addr[1:0])) begin
                  fault_d = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  fault_d = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_REQ: begin
            ls_stall  = 1'b1;
            mem_req   = 1'b1;
            mem_we    = write_q;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = align_wdata;
            mem_be    = align_be;
            // An ack in the final allowed cycle still completes the access cleanly.
            if (mem_ack) begin
               rdata_d = write_q ? 32'd0 : align_ldata;
               fault_d = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               fault_d = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            ls_done  = 1'b1;
            ls_fault = fault_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ls_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ------------------------------------------------------------------
// tb_load_store_unit : directed vectors with a queue-based scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ls_valid = 1'b0;
   logic        ls_write = 1'b0;
   logic [2:0]  ls_funct3 = 3'b000;
   logic [31:0] ls_addr = 32'd0;
   logic [31:0] ls_wdata = 32'd0;
   logic        ls_stall, ls_done, ls_fault;
   logic [31:0] ls_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata = 32'd0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } res_t;

   req_t req_q[$];
   res_t res_q[$];
   req_t req_e;
   res_t res_e;

   int n_vec = 0;
   int n_err = 0;

   int          ack_after  = 0;
   logic [31:0] resp_word  = 32'd0;
   logic        ack_gen    = 1'b0;
   logic        stray_ack  = 1'b0;
   int          req_cycles = 0;
   logic        req_prev   = 1'b0;
   logic [31:0] held_addr  = 32'd0;

   assign mem_ack = ack_gen | stray_ack;

   always #5 clock = ~clock;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .ls_valid  (ls_valid),
      .ls_write  (ls_write),
      .ls_funct3 (ls_funct3),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_stall  (ls_stall),
      .ls_done   (ls_done),
      .ls_rdata  (ls_rdata),
      .ls_fault  (ls_fault),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: ack after ack_after request cycles (0 = never).
   always @(negedge clock) begin
      if (mem_req) begin
         req_cycles = req_cycles + 1;
         ack_gen    = (ack_after > 0) && (req_cycles == ack_after);
         mem_rdata  = resp_word;
      end else begin
         req_cycles = 0;
         ack_gen    = 1'b0;
      end
   end

   // Monitor: checks each new request and each completion against the queues.
   always @(negedge clock) begin
      if (mem_req && !req_prev) begin
         if (req_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
         end else begin
            req_e = req_q.pop_front();
            chk("mem_we",   {31'd0, mem_we}, {31'd0, req_e.we});
            chk("mem_addr", mem_addr, req_e.addr);
            chk("mem_be",   {28'd0, mem_be}, {28'd0, req_e.be});
            if (req_e.we) chk("mem_wdata", mem_wdata, req_e.wdata);
         end
         held_addr = mem_addr;
      end else if (mem_req && req_prev) begin
         chk("mem_addr_held", mem_addr, held_addr);
      end
      req_prev = mem_req;

      if (ls_done) begin
         if (res_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done: got ls_done=1 expected 0");
         end else begin
            res_e = res_q.pop_front();
            chk("ls_rdata", ls_rdata, res_e.rdata);
            chk("ls_fault", {31'd0, ls_fault}, {31'd0, res_e.fault});
         end
      end
   end

   task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack, input logic [31:0] word,
                         input logic has_req, input logic [3:0] be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_fault, input int exp_lat);
      int   lat;
      int   stall_n;
      logic seen;
      req_t r;
      res_t s;
      r.we = w; r.addr = {addr[31:2], 2'b00}; r.wdata = exp_wd; r.be = be;
      s.rdata = exp_rd; s.fault = exp_fault;
      if (has_req) req_q.push_back(r);
      res_q.push_back(s);
      ack_after = ack;
      resp_word = word;
      @(posedge clock); #1;
      ls_valid = 1'b1; ls_write = w; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
      lat = 0; stall_n = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clock);
         if (ls_done) begin
            seen = 1'b1;
            lat  = c;
            ls_valid = 1'b0;
         end else if (ls_stall) begin
            stall_n++;
         end
      end
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL done_timeout: got no ls_done expected done after %0d cycles", exp_lat);
         ls_valid = 1'b0;
      end else begin
         chk("done_latency", lat, exp_lat);
         chk("stall_cycles", stall_n, exp_lat);
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_stall",    {31'd0, ls_stall}, 32'd0);
      chk("rst_done",     {31'd0, ls_done},  32'd0);
      chk("rst_fault",    {31'd0, ls_fault}, 32'd0);
      chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
      chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
      chk("rst_mem_addr", mem_addr,          32'd0);
      chk("rst_mem_wdata", mem_wdata,        32'd0);
      chk("rst_mem_be",   {28'd0, mem_be},   32'd0);
      chk("rst_rdata",    ls_rdata,          32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      //      w     f3      addr          wdata         ack word          req  be       exp_wdata     exp_rdata     flt  lat
      run_op(1'b0, 3'b010, 32'h01000104, 32'h0,        2, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 3);
      run_op(1'b0, 3'b000, 32'h01000103, 32'h0,        1, 32'h80AA55CC, 1'b1, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 2);
      run_op(1'b0, 3'b100, 32'h01000103, 32'h0,        1, 32'h80AA55CC, 1'b1, 4'b1000, 32'h0,        32'h00000080, 1'b0, 2);
      run_op(1'b0, 3'b101, 32'h01000102, 32'h0,        1, 32'h80AA55CC, 1'b1, 4'b1100, 32'h0,        32'h000080AA, 1'b0, 2);
      run_op(1'b0, 3'b001, 32'h01000100, 32'h0,        1, 32'h1234F00D, 1'b1, 4'b0011, 32'h0,        32'hFFFFF00D, 1'b0, 2);
      run_op(1'b1, 3'b001, 32'h01000102, 32'h1234ABCD, 1, 32'h55555555, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 2);
      run_op(1'b1, 3'b000, 32'h01000101, 32'h000000A5, 1, 32'h55555555, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 2);
      run_op(1'b1, 3'b010, 32'h01000108, 32'hCAFEF00D, 3, 32'h55555555, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 4);
      run_op(1'b0, 3'b010, 32'h01000102, 32'h0,        1, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
      run_op(1'b0, 3'b001, 32'h01000101, 32'h0,        1, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
      run_op(1'b0, 3'b011, 32'h01000100, 32'h0,        1, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
      run_op(1'b1, 3'b100, 32'h01000100, 32'h0,        1, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
      run_op(1'b0, 3'b010, 32'h01000200, 32'h0,        0, 32'h99999999, 1'b1, 4'b1111, 32'h0,        32'h0,        1'b1, 5);
      run_op(1'b0, 3'b010, 32'h01000204, 32'h0,        4, 32'h11223344, 1'b1, 4'b1111, 32'h0,        32'h11223344, 1'b0, 5);

      // Reset while a load is in REQ, then a stray ack after the reset.
      req_e.we = 1'b0; req_e.addr = 32'h01000300; req_e.wdata = 32'h0; req_e.be = 4'b1111;
      req_q.push_back(req_e);
      ack_after = 0;
      @(posedge clock); #1;
      ls_valid = 1'b1; ls_write = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h01000300;
      @(posedge clock); #1;
      reset = 1'b1; ls_valid = 1'b0;
      @(negedge clock);
      chk("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
      @(posedge clock); #1;
      reset = 1'b0; stray_ack = 1'b1; resp_word = 32'hBADBAD00;
      @(negedge clock);
      chk("rst_mid_req_after", {31'd0, mem_req}, 32'd0);
      chk("rst_mid_stall",     {31'd0, ls_stall}, 32'd0);
      @(posedge clock); #1;
      stray_ack = 1'b0;
      repeat (3) begin
         @(negedge clock);
         chk("late_ack_req",  {31'd0, mem_req}, 32'd0);
         chk("late_ack_done", {31'd0, ls_done}, 32'd0);
      end
      run_op(1'b0, 3'b010, 32'h01000304, 32'h0,        1, 32'h0BADF00D, 1'b1, 4'b1111, 32'h0,        32'h0BADF00D, 1'b0, 2);

      repeat (3) @(negedge clock);
      chk("req_queue_empty", req_q.size(), 32'd0);
      chk("res_queue_empty", res_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
